// File: rtl/hls_activity_monitor_if.sv
// Handshake bundle of the monitored HLS block and its loop.
interface hls_activity_monitor_if;
  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_continue;
  logic loop_start;
  logic loop_ready;
  logic loop_done;
  logic loop_continue;

  // Driver side (the monitored block, or a testbench standing in for it)
  modport master (
    output ap_start, ap_ready, ap_done, ap_continue,
    output loop_start, loop_ready, loop_done, loop_continue
  );

  // Observer side (the activity monitor)
  modport slave (
    input ap_start, ap_ready, ap_done, ap_continue,
    input loop_start, loop_ready, loop_done, loop_continue
  );
endinterface

// File: rtl/hls_activity_monitor.sv
// Activity monitor for one HLS block (ap_ctrl_hs) and one of its loops.
// Counts transactions, latency, loop invocations, iterations and stalls.
// All counters saturate and freeze permanently once finish is seen.
module hls_activity_monitor #(
  parameter int unsigned STATE_W = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                finish,
  hls_activity_monitor_if.slave hs,
  input  logic [STATE_W-1:0]  cur_state,
  input  logic [STATE_W-1:0]  iter_start_state,
  input  logic [STATE_W-1:0]  iter_end_state,
  input  logic [STATE_W-1:0]  quit_state,
  input  logic                iter_start_block,
  input  logic                iter_end_block,
  input  logic                quit_block,
  input  logic                iter_start_enable,
  input  logic                iter_end_enable,
  input  logic                quit_enable,
  input  logic                quit_at_end,
  output logic                mod_busy,
  output logic [CNT_W-1:0]    mod_start_cnt,
  output logic [CNT_W-1:0]    mod_done_cnt,
  output logic [CNT_W-1:0]    mod_last_lat,
  output logic                loop_active,
  output logic [CNT_W-1:0]    loop_inv_cnt,
  output logic [CNT_W-1:0]    loop_iter_cnt,
  output logic [CNT_W-1:0]    loop_last_trip,
  output logic [CNT_W-1:0]    loop_stall_cnt,
  output logic                frozen
);

  typedef enum logic {M_IDLE = 1'b0, M_BUSY = 1'b1} mod_state_e;
  typedef enum logic {L_IDLE = 1'b0, L_RUN  = 1'b1} loop_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Saturating increment shared by every counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  mod_state_e       mod_state_q,  mod_state_d;
  loop_state_e      loop_state_q, loop_state_d;
  logic [CNT_W-1:0] start_cnt_q,  start_cnt_d;
  logic [CNT_W-1:0] done_cnt_q,   done_cnt_d;
  logic [CNT_W-1:0] lat_q,        lat_d;
  logic [CNT_W-1:0] last_lat_q,   last_lat_d;
  logic [CNT_W-1:0] trip_q,       trip_d;
  logic [CNT_W-1:0] inv_cnt_q,    inv_cnt_d;
  logic [CNT_W-1:0] iter_cnt_q,   iter_cnt_d;
  logic [CNT_W-1:0] last_trip_q,  last_trip_d;
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic             frozen_q,     frozen_d;

  // loop_ready carries no information the monitor needs
  logic loop_ready_unused;
  assign loop_ready_unused = hs.loop_ready;

  logic             start_evt, done_evt, mod_busy_now;
  logic [CNT_W-1:0] cur_lat;
  logic             loop_run, iter_end_evt, quit_evt, iter_inc, loop_end, stall_evt;
  logic [CNT_W-1:0] trip_now;

  // Event decode for the current cycle
  always_comb begin
    start_evt    = hs.ap_start & hs.ap_ready;
    done_evt     = hs.ap_done & hs.ap_continue;
    mod_busy_now = (mod_state_q == M_BUSY);
    // Inclusive cycle count of the transaction as of this cycle
    cur_lat      = start_evt ? CNT_ONE : sat_inc(lat_q);

    loop_run     = (loop_state_q == L_RUN);
    iter_end_evt = (cur_state == iter_end_state) & ~iter_end_block & iter_end_enable & loop_run;
    quit_evt     = (cur_state == quit_state) & ~quit_block & quit_enable &
                   hs.loop_done & hs.loop_continue & loop_run;
    // A quit only closes an iteration when it coincides with the final iteration end
    iter_inc     = iter_end_evt | (quit_evt & quit_at_end);
    loop_end     = loop_run & hs.loop_done & hs.loop_continue;
    stall_evt    = loop_run & (cur_state == iter_start_state) & iter_start_block & iter_start_enable;
    trip_now     = iter_inc ? sat_inc(trip_q) : trip_q;
  end

  // Next-state for both FSMs and all counters; everything holds while frozen
  always_comb begin
    mod_state_d  = mod_state_q;
    loop_state_d = loop_state_q;
    start_cnt_d  = start_cnt_q;
    done_cnt_d   = done_cnt_q;
    lat_d        = lat_q;
    last_lat_d   = last_lat_q;
    trip_d       = trip_q;
    inv_cnt_d    = inv_cnt_q;
    iter_cnt_d   = iter_cnt_q;
    last_trip_d  = last_trip_q;
    stall_cnt_d  = stall_cnt_q;
    frozen_d     = frozen_q | finish;

    if (!frozen_q) begin
      if (start_evt) start_cnt_d = sat_inc(start_cnt_q);
      if (done_evt)  done_cnt_d  = sat_inc(done_cnt_q);
      if (done_evt && (mod_busy_now || hs.ap_start)) last_lat_d = cur_lat;

      case (mod_state_q)
        M_IDLE:  if (hs.ap_start && !done_evt) mod_state_d = M_BUSY;
        M_BUSY:  if (done_evt && !hs.ap_start) mod_state_d = M_IDLE;
        default: mod_state_d = M_IDLE;
      endcase
      lat_d = (mod_state_d == M_BUSY) ? cur_lat : '0;

      if (iter_inc)  iter_cnt_d  = sat_inc(iter_cnt_q);
      if (stall_evt) stall_cnt_d = sat_inc(stall_cnt_q);
      trip_d = trip_now;

      case (loop_state_q)
        L_IDLE: begin
          if (hs.loop_start) begin
            loop_state_d = L_RUN;
            trip_d       = '0;
          end
        end
        L_RUN: begin
          if (loop_end) begin
            inv_cnt_d   = sat_inc(inv_cnt_q);
            last_trip_d = trip_now;
            if (hs.loop_start) begin
              trip_d = '0;
            end else begin
              loop_state_d = L_IDLE;
            end
          end
        end
        default: loop_state_d = L_IDLE;
      endcase
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      mod_state_q  <= M_IDLE;
      loop_state_q <= L_IDLE;
      start_cnt_q  <= '0;
      done_cnt_q   <= '0;
      lat_q        <= '0;
      last_lat_q   <= '0;
      trip_q       <= '0;
      inv_cnt_q    <= '0;
      iter_cnt_q   <= '0;
      last_trip_q  <= '0;
      stall_cnt_q  <= '0;
      frozen_q     <= 1'b0;
    end else begin
      mod_state_q  <= mod_state_d;
      loop_state_q <= loop_state_d;
      start_cnt_q  <= start_cnt_d;
      done_cnt_q   <= done_cnt_d;
      lat_q        <= lat_d;
      last_lat_q   <= last_lat_d;
      trip_q       <= trip_d;
      inv_cnt_q    <= inv_cnt_d;
      iter_cnt_q   <= iter_cnt_d;
      last_trip_q  <= last_trip_d;
      stall_cnt_q  <= stall_cnt_d;
      frozen_q     <= frozen_d;
    end
  end

  assign mod_busy       = (mod_state_q == M_BUSY);
  assign mod_start_cnt  = start_cnt_q;
  assign mod_done_cnt   = done_cnt_q;
  assign mod_last_lat   = last_lat_q;
  assign loop_active    = (loop_state_q == L_RUN);
  assign loop_inv_cnt   = inv_cnt_q;
  assign loop_iter_cnt  = iter_cnt_q;
  assign loop_last_trip = last_trip_q;
  assign loop_stall_cnt = stall_cnt_q;
  assign frozen         = frozen_q;

endmodule

// File: tb/tb_hls_activity_monitor.sv
// Directed bench for hls_activity_monitor: a 32-bit instance plus a 4-bit
// instance sharing the same stimulus, the latter for saturation.
module tb_hls_activity_monitor;

  logic clk = 1'b0;
  logic reset, finish;
  logic cur_state, iter_start_state, iter_end_state, quit_state;
  logic iter_start_block, iter_end_block, quit_block;
  logic iter_start_enable, iter_end_enable, quit_enable, quit_at_end;

  logic        mod_busy, loop_active, frozen;
  logic [31:0] mod_start_cnt, mod_done_cnt, mod_last_lat;
  logic [31:0] loop_inv_cnt, loop_iter_cnt, loop_last_trip, loop_stall_cnt;

  logic        s_mod_busy, s_loop_active, s_frozen;
  logic [3:0]  s_mod_start_cnt, s_mod_done_cnt, s_mod_last_lat;
  logic [3:0]  s_loop_inv_cnt, s_loop_iter_cnt, s_loop_last_trip, s_loop_stall_cnt;

  int errors = 0;
  int checks = 0;

  hls_activity_monitor_if hs ();

  always #5 clk = ~clk;

  hls_activity_monitor #(.STATE_W(1), .CNT_W(32)) dut (
    .clock(clk), .reset(reset), .finish(finish), .hs(hs),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
    .quit_block(quit_block), .iter_start_enable(iter_start_enable),
    .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
    .quit_at_end(quit_at_end),
    .mod_busy(mod_busy), .mod_start_cnt(mod_start_cnt), .mod_done_cnt(mod_done_cnt),
    .mod_last_lat(mod_last_lat), .loop_active(loop_active), .loop_inv_cnt(loop_inv_cnt),
    .loop_iter_cnt(loop_iter_cnt), .loop_last_trip(loop_last_trip),
    .loop_stall_cnt(loop_stall_cnt), .frozen(frozen)
  );

  hls_activity_monitor #(.STATE_W(1), .CNT_W(4)) dut_sat (
    .clock(clk), .reset(reset), .finish(finish), .hs(hs),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
    .quit_block(quit_block), .iter_start_enable(iter_start_enable),
    .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
    .quit_at_end(quit_at_end),
    .mod_busy(s_mod_busy), .mod_start_cnt(s_mod_start_cnt), .mod_done_cnt(s_mod_done_cnt),
    .mod_last_lat(s_mod_last_lat), .loop_active(s_loop_active), .loop_inv_cnt(s_loop_inv_cnt),
    .loop_iter_cnt(s_loop_iter_cnt), .loop_last_trip(s_loop_last_trip),
    .loop_stall_cnt(s_loop_stall_cnt), .frozen(s_frozen)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic busy, input logic [31:0] st,
                         input logic [31:0] dn, input logic [31:0] lat, input logic act,
                         input logic [31:0] inv, input logic [31:0] itc, input logic [31:0] trip,
                         input logic [31:0] stl, input logic frz);
    chk({tag, ".busy"},   64'(mod_busy),       64'(busy));
    chk({tag, ".start"},  64'(mod_start_cnt),  64'(st));
    chk({tag, ".done"},   64'(mod_done_cnt),   64'(dn));
    chk({tag, ".lat"},    64'(mod_last_lat),   64'(lat));
    chk({tag, ".active"}, 64'(loop_active),    64'(act));
    chk({tag, ".inv"},    64'(loop_inv_cnt),   64'(inv));
    chk({tag, ".iter"},   64'(loop_iter_cnt),  64'(itc));
    chk({tag, ".trip"},   64'(loop_last_trip), 64'(trip));
    chk({tag, ".stall"},  64'(loop_stall_cnt), 64'(stl));
    chk({tag, ".frozen"}, 64'(frozen),         64'(frz));
  endtask

  initial begin
    // Reset for two cycles with random inputs
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      finish            = 1'($urandom);
      hs.ap_start       = 1'($urandom);
      hs.ap_ready       = 1'($urandom);
      hs.ap_done        = 1'($urandom);
      hs.ap_continue    = 1'($urandom);
      hs.loop_start     = 1'($urandom);
      hs.loop_ready     = 1'($urandom);
      hs.loop_done      = 1'($urandom);
      hs.loop_continue  = 1'($urandom);
      cur_state         = 1'($urandom);
      iter_start_state  = 1'($urandom);
      iter_end_state    = 1'($urandom);
      quit_state        = 1'($urandom);
      iter_start_block  = 1'($urandom);
      iter_end_block    = 1'($urandom);
      quit_block        = 1'($urandom);
      iter_start_enable = 1'($urandom);
      iter_end_enable   = 1'($urandom);
      quit_enable       = 1'($urandom);
      quit_at_end       = 1'($urandom);
      step();
    end
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset.sat_start", 64'(s_mod_start_cnt), 64'd0);

    // Idle configuration: all codes 0, enables 1, blocks 0
    reset = 1'b1; finish = 1'b0;
    hs.ap_start = 0; hs.ap_ready = 0; hs.ap_done = 0; hs.ap_continue = 1;
    hs.loop_start = 0; hs.loop_ready = 0; hs.loop_done = 0; hs.loop_continue = 1;
    cur_state = 0; iter_start_state = 0; iter_end_state = 0; quit_state = 0;
    iter_start_block = 0; iter_end_block = 0; quit_block = 0;
    iter_start_enable = 1; iter_end_enable = 1; quit_enable = 1; quit_at_end = 0;
    repeat (10) step();
    chk_all("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Transaction: start at cycle 0, done at cycle 5 -> latency 6
    hs.ap_start = 1; hs.ap_ready = 1;
    step();
    chk("txn.busy_mid", 64'(mod_busy), 64'd1);
    chk("txn.start_mid", 64'(mod_start_cnt), 64'd1);
    hs.ap_start = 0; hs.ap_ready = 0;
    repeat (4) step();
    hs.ap_done = 1;
    step();
    hs.ap_done = 0;
    chk_all("txn", 0, 1, 1, 6, 0, 0, 0, 0, 0, 0);

    // Single-cycle transaction -> latency 1, stays idle
    hs.ap_start = 1; hs.ap_ready = 1; hs.ap_done = 1;
    step();
    hs.ap_start = 0; hs.ap_ready = 0; hs.ap_done = 0;
    chk_all("txn1", 0, 2, 2, 1, 0, 0, 0, 0, 0, 0);

    // Loop: 8 active cycles, iteration end every cycle, done on the 8th
    hs.loop_start = 1;
    step();
    hs.loop_start = 0;
    chk("loop.active", 64'(loop_active), 64'd1);
    repeat (7) step();
    hs.loop_done = 1;
    step();
    hs.loop_done = 0;
    chk_all("loop8", 0, 2, 2, 1, 0, 1, 8, 8, 0, 0);

    // Loop with the first 3 active cycles stalled -> 5 iterations, 3 stalls
    hs.loop_start = 1;
    step();
    hs.loop_start = 0;
    iter_start_block = 1; iter_end_block = 1;
    repeat (3) step();
    iter_start_block = 0; iter_end_block = 0;
    repeat (4) step();
    hs.loop_done = 1;
    step();
    hs.loop_done = 0;
    chk_all("stall", 0, 2, 2, 1, 0, 2, 13, 5, 3, 0);

    // No iteration ends; quit at end counts as the single iteration
    hs.loop_start = 1;
    step();
    hs.loop_start = 0;
    iter_end_enable = 0; quit_at_end = 1;
    repeat (2) step();
    hs.loop_done = 1;
    step();
    hs.loop_done = 0;
    iter_end_enable = 1; quit_at_end = 0;
    chk_all("quit", 0, 2, 2, 1, 0, 3, 14, 1, 3, 0);

    // Finish mid-loop and mid-transaction; events on the finish cycle count
    hs.loop_start = 1;
    step();
    hs.loop_start = 0;
    step();
    finish = 1; hs.ap_start = 1; hs.ap_ready = 1;
    step();
    finish = 0; hs.ap_start = 0; hs.ap_ready = 0;
    chk_all("finish", 1, 3, 2, 1, 1, 3, 16, 1, 3, 1);
    hs.ap_start = 1; hs.ap_ready = 1; hs.ap_done = 1;
    hs.loop_done = 1; hs.loop_start = 1; iter_start_block = 1;
    repeat (5) step();
    hs.ap_start = 0; hs.ap_ready = 0; hs.ap_done = 0;
    hs.loop_done = 0; hs.loop_start = 0; iter_start_block = 0;
    step();
    chk_all("frozen", 1, 3, 2, 1, 1, 3, 16, 1, 3, 1);

    // Reset mid-work clears everything including frozen
    reset = 0;
    step();
    reset = 1;
    chk_all("rst2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst2.sat_frozen", 64'(s_frozen), 64'd0);

    // Saturation on the 4-bit instance
    hs.ap_start = 1; hs.ap_ready = 1; hs.ap_done = 1;
    repeat (15) step();
    chk("sat15.narrow", 64'(s_mod_start_cnt), 64'd15);
    chk("sat15.wide", 64'(mod_start_cnt), 64'd15);
    step();
    hs.ap_start = 0; hs.ap_ready = 0; hs.ap_done = 0;
    chk("sat16.narrow", 64'(s_mod_start_cnt), 64'd15);
    chk("sat16.narrow_done", 64'(s_mod_done_cnt), 64'd15);
    chk("sat16.wide", 64'(mod_start_cnt), 64'd16);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
